ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Read-side DMA: drains a contiguous block of the dual-port RAM (filled by the ROM-to-RAM DMA) onto a
//  valid/ready stream. Drives one RAM read port (1-cycle registered read latency) and buffers returned
//  words in a 2-entry output FIFO, so downstream backpressure never loses data. Full-rate when m_ready=1.
// PARAMETERS
//  DATA_WIDTH  8  width of a RAM word and of m_data
//  ADDR_WIDTH  4  RAM address width; RAM depth = 2**ADDR_WIDTH
// PORTS
//  clk        in   1             clock; all logic on posedge
//  rst        in   1             reset, synchronous, active-high
//  start      in   1             begin transfer; sampled only when busy=0
//  base_addr  in   ADDR_WIDTH    first RAM address, captured on accepted start
//  len        in   ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH, captured on accepted start
//  busy       out  1             transfer in progress
//  done       out  1             one-cycle pulse at end of transfer
//  ram_en     out  1             RAM read strobe
//  ram_addr   out  ADDR_WIDTH    RAM read address
//  ram_rdata  in   DATA_WIDTH    RAM read data, valid the cycle after ram_en
//  m_valid    out  1             stream word valid
//  m_ready    in   1             stream consumer ready
//  m_data     out  DATA_WIDTH    stream word
//  m_last     out  1             marks final word of transfer (qualified by m_valid)
// BEHAVIOUR
//  - Reset: busy=0, done=0, ram_en=0, ram_addr=0, m_valid=0, m_data=0, m_last=0; FIFO, counters cleared.
//    Reset mid-transfer aborts immediately; in-flight read data is discarded; no done pulse.
//  - FSM: IDLE -> (start, len>0) RUN -> (last word handshaken) FIN -> IDLE. IDLE -> (start, len=0) FIN.
//    FIN lasts one cycle: done=1, busy=0. busy=1 in RUN only. start while busy=1 is ignored.
//  - Latency: start high in cycle T -> ram_en=1, ram_addr=base_addr in T+1 -> data captured into FIFO
//    at end of T+2 -> m_valid=1 in T+3.
//  - Issue rule (RUN): ram_en=1 iff issued<len AND credit>0, credit = 2 - fifo_count - inflight
//    + (m_valid & m_ready). inflight = ram_en of previous cycle. Guarantees FIFO never overflows.
//  - Address: ram_addr = base_addr + issued, modulo 2**ADDR_WIDTH (wraps from max to 0).
//  - Counters: issued and accepted are ADDR_WIDTH+1 bits; len=2**ADDR_WIDTH reads every word once.
//  - Stream: m_data/m_valid come from FIFO head; word held stable until m_valid & m_ready.
//    m_last=1 with the word where accepted == len-1. Words emitted in address order, none dropped/duped.
//  - Throughput: with m_ready held 1, one word per cycle from T+3 to T+2+len.
//  - done pulses the cycle after the m_last handshake; the next start is accepted in that FIN cycle? No:
//    start is accepted only in IDLE (cycle after FIN onward).
//  - Simultaneous FIFO push and pop in same cycle: count unchanged, order preserved.
// TESTING
//  1 RAM[3..6]=A0..A3, base=3 len=4, m_ready=1 -> ram_en T+1..T+4, beats A0..A3 at T+3..T+6,
//    m_last on A3, done pulse T+7, busy=0 at T+7.
//  2 Same data, m_ready toggled 1,0,0,1,... -> same 4 words in order, each held stable while m_ready=0,
//    never more than 2 outstanding reads+buffered words.
//  3 base=14 len=4 -> ram_addr sequence 14,15,0,1; data matches RAM[14],RAM[15],RAM[0],RAM[1].
//  4 len=0 -> no ram_en, no m_valid, done pulse in T+1; len=16 base=5 -> 16 beats, addr 5..15,0..4.
//  5 rst asserted after 2 beats of len=8 -> next cycle all outputs 0, no done; fresh start then
//    completes a clean len=3 transfer.
//  6 start pulsed again mid-transfer with different base/len -> ignored; original transfer unaffected.

Source files
------------

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: drains a contiguous RAM block onto a valid/ready stream.
// Rev 1.0 - credit-limited read issue feeding a 2-entry skid FIFO.
`default_nettype none

module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   accepted;
  logic                  inflight;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;

  logic                  push;
  logic                  pop;
  logic [2:0]            used;
  logic                  can_issue;

  // A read returns one cycle after ram_en, so the inflight flag is the push strobe.
  assign push = inflight;
  assign pop  = m_valid & m_ready;

  // Buffered words plus the read in flight must leave room for a new read;
  // a word leaving this cycle frees its slot in time for the new return.
  assign used      = {1'b0, fifo_count} + {2'b00, inflight};
  assign can_issue = (used < 3'd2) || (pop && (used == 3'd2));

  assign ram_en   = (state == S_RUN) && (issued < len_q) && can_issue;
  assign ram_addr = base_q + issued[ADDR_WIDTH-1:0];

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_mem[rd_ptr];
  assign m_last  = m_valid && (accepted == (len_q - CNT_ONE));

  assign busy = (state == S_RUN);
  assign done = (state == S_FIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= ram_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= ram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued   <= '0;
      accepted <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= len;
            issued   <= '0;
            accepted <= '0;
            state    <= (len != '0) ? S_RUN : S_FIN;
          end
        end
        S_RUN: begin
          if (ram_en) begin
            issued <= issued + CNT_ONE;
          end
          if (pop) begin
            accepted <= accepted + CNT_ONE;
            if (m_last) begin
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: scoreboard bench with a registered-read RAM model.
// Rev 1.0
`default_nettype none

module tb_ram_stream_reader;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          start     = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len       = '0;
  logic          busy;
  logic          done;
  logic          ram_en;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata = '0;
  logic          m_valid;
  logic          m_ready   = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(32'hA0 + i - 3);
  end

  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];

  int t0, rd_cnt, hs_cnt, beats, done_cnt, first_en, first_beat, last_beat, done_cyc, max_out;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  int ready_mode = 0;
  int rpat       = 0;

  task automatic clear_track();
    rd_cnt = 0; hs_cnt = 0; beats = 0; done_cnt = 0; max_out = 0;
    first_en = -1; first_beat = -1; last_beat = -1; done_cyc = -1;
  endtask

  // Stream consumer: always ready, a 1,0,0 pattern, or random.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       begin m_ready = (rpat % 3 == 0); rpat++; end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_en) begin
        rd_cnt++;
        if (first_en < 0) first_en = cyc;
        if (addr_q.size() == 0) check("addr_extra", 32'(ram_addr), 32'hFFFF);
        else check("addr", 32'(ram_addr), 32'(addr_q.pop_front()));
      end
      if (prev_stall) check("hold", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
      if (m_valid && m_ready) begin
        logic [DW:0] e;
        hs_cnt++;
        beats++;
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        if (exp_q.size() == 0) begin
          check("beat_extra", 32'(m_data), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(m_data), 32'(e[DW-1:0]));
          check("last", 32'(m_last), 32'(e[DW]));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (rd_cnt - hs_cnt > max_out) max_out = rd_cnt - hs_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", 32'(busy), 32'd0);
      end
    end
  end

  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW:0] l);
    @(posedge clk); #1;
    clear_track();
    base_addr = b;
    len       = l;
    start     = 1'b1;
    t0        = cyc;
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back({(i == int'(l) - 1), mem[AW'(int'(b) + i)]});
      addr_q.push_back(AW'(int'(b) + i));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_checks(input string tag, input int l);
    check({tag, "_beats"}, 32'(beats), 32'(l));
    check({tag, "_reads"}, 32'(rd_cnt), 32'(l));
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_max_out_ok"}, 32'(max_out <= 2), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'({busy, done, ram_en, ram_addr, m_valid, m_data, m_last}), 32'd0);
    rst = 1'b0;

    // Full-rate transfer with exact cycle timing.
    ready_mode = 0;
    start_xfer(4'd3, 5'd4);
    wait_done(40, "t1");
    check("t1_first_en", 32'(first_en), 32'(t0 + 1));
    check("t1_first_beat", 32'(first_beat), 32'(t0 + 3));
    check("t1_last_beat", 32'(last_beat), 32'(t0 + 6));
    check("t1_done_cyc", 32'(done_cyc), 32'(t0 + 7));
    end_checks("t1", 4);

    // Backpressure 1,0,0 pattern.
    ready_mode = 1; rpat = 0;
    start_xfer(4'd3, 5'd4);
    wait_done(80, "t2");
    end_checks("t2", 4);

    // Address wrap.
    ready_mode = 0;
    start_xfer(4'd14, 5'd4);
    wait_done(40, "t3");
    end_checks("t3", 4);

    // Zero-length and full-depth transfers.
    start_xfer(4'd7, 5'd0);
    wait_done(20, "t4a");
    check("t4a_done_cyc", 32'(done_cyc), 32'(t0 + 1));
    check("t4a_reads", 32'(rd_cnt), 32'd0);
    check("t4a_beats", 32'(beats), 32'd0);
    check("t4a_done_cnt", 32'(done_cnt), 32'd1);
    start_xfer(4'd5, 5'd16);
    wait_done(80, "t4b");
    check("t4b_last_beat", 32'(last_beat), 32'(t0 + 18));
    end_checks("t4b", 16);

    // Random backpressure.
    ready_mode = 2;
    start_xfer(4'd9, 5'd11);
    wait_done(300, "tr");
    end_checks("tr", 11);

    // Start during a transfer is ignored.
    ready_mode = 1; rpat = 0;
    start_xfer(4'd2, 5'd6);
    repeat (3) @(posedge clk);
    #1;
    base_addr = 4'd9; len = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(120, "t6");
    end_checks("t6", 6);

    // Reset mid-transfer aborts cleanly.
    ready_mode = 0;
    start_xfer(4'd0, 5'd8);
    begin
      int n = 0;
      while (beats < 2 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("t5_two_beats", 32'(beats >= 2), 32'd1);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_outs", 32'({busy, done, ram_en, ram_addr, m_valid, m_data, m_last}), 32'd0);
    exp_q.delete();
    addr_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", 32'(done_cnt), 32'd0);
    check("t5_idle_outs", 32'({busy, ram_en, m_valid}), 32'd0);
    start_xfer(4'd7, 5'd3);
    wait_done(40, "t5");
    end_checks("t5", 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
